// File: rtl/data_memory_dump.sv
// Debug-side sweeper for the data memory debug port: reads a contiguous range and streams it out.
// Optional build macro DATA_MEMORY_DUMP_CHECKSUM_EN appends a modulo-2^DATA_W checksum beat.
module data_memory_dump #(
  parameter int D_ADDR_W       = 12,
  parameter int DATA_W         = 8,
  parameter int D_MEMORY_DEPTH = 1 << D_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [D_ADDR_W-1:0] start_addr,
  input  logic [D_ADDR_W:0]   length,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                debug_enable,
  output logic [D_ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0]   debug_rdata,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_STREAM = 3'd2,
`ifdef DATA_MEMORY_DUMP_CHECKSUM_EN
    S_CSUM   = 3'd3,
`endif
    S_DONE   = 3'd4
  } state_t;

  localparam logic [D_ADDR_W:0]   DEPTH_L  = (D_ADDR_W+1)'(D_MEMORY_DEPTH);
  localparam logic [D_ADDR_W:0]   REM_ONE  = (D_ADDR_W+1)'(1);
  localparam logic [D_ADDR_W:0]   REM_ZERO = '0;
  localparam logic [D_ADDR_W-1:0] ADDR_ONE = D_ADDR_W'(1);

  state_t              state;
  logic [D_ADDR_W-1:0] fetch_addr;
  logic [D_ADDR_W:0]   remaining;
`ifdef DATA_MEMORY_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   sum;
`endif

  // Stream handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // out_data/out_last hold steady while out_valid is high and out_ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      fetch_addr <= '0;
      remaining  <= '0;
      out_data   <= '0;
`ifdef DATA_MEMORY_DUMP_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            fetch_addr <= start_addr;
            remaining  <= (length > DEPTH_L) ? DEPTH_L : length;
`ifdef DATA_MEMORY_DUMP_CHECKSUM_EN
            sum <= '0;
            if (length == REM_ZERO) begin
              out_data <= '0;
              state    <= S_CSUM;
            end else begin
              state <= S_FILL;
            end
`else
            state <= (length == REM_ZERO) ? S_DONE : S_FILL;
`endif
          end
        end

        S_FILL: begin
          if (abort) begin
            state <= S_DONE;
          end else begin
            out_data   <= debug_rdata;
            fetch_addr <= fetch_addr + ADDR_ONE;
            state      <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (out_ready) begin
`ifdef DATA_MEMORY_DUMP_CHECKSUM_EN
            sum <= sum + out_data;
`endif
            if (abort) begin
              state <= S_DONE;
            end else if (remaining == REM_ONE) begin
`ifdef DATA_MEMORY_DUMP_CHECKSUM_EN
              // The checksum beat includes the final data beat being accepted now.
              out_data <= sum + out_data;
              state    <= S_CSUM;
`else
              state <= S_DONE;
`endif
            end else begin
              remaining  <= remaining - REM_ONE;
              out_data   <= debug_rdata;
              fetch_addr <= fetch_addr + ADDR_ONE;
            end
          end else if (abort) begin
            state <= S_DONE;
          end
        end

`ifdef DATA_MEMORY_DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (abort || out_ready) state <= S_DONE;
        end
`endif

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode only from registered state, so they carry no input-to-output paths.
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign debug_addr = fetch_addr;
  assign dbg_state  = state;

`ifdef DATA_MEMORY_DUMP_CHECKSUM_EN
  assign debug_enable = (state == S_FILL) || (state == S_STREAM) || (state == S_CSUM);
  assign out_valid    = (state == S_STREAM) || (state == S_CSUM);
  assign out_last     = (state == S_CSUM);
`else
  assign debug_enable = (state == S_FILL) || (state == S_STREAM);
  assign out_valid    = (state == S_STREAM);
  assign out_last     = out_valid && (remaining == REM_ONE);
`endif

endmodule

// File: doc/data_memory_dump.md
# data_memory_dump

Debug-side reader for the data memory's debug port. On a start command it takes ownership of the port (`debug_enable`, `debug_addr`), sweeps a contiguous address range and streams each byte out on a valid/ready interface toward the debug host link. It is the consumer end of the memory's debug interface. While it owns the port, core writes to data memory are suppressed, so the core controller stalls on `busy`.

## Interface
- `D_ADDR_W`, 12, data memory address width
- `DATA_W`, 8, data word width
- `D_MEMORY_DEPTH`, 1 << D_ADDR_W, words in data memory; length saturation limit

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request a dump; sampled only in IDLE
- `start_addr`  in  D_ADDR_W  first address to read
- `length`  in  D_ADDR_W+1  number of words to read
- `abort`  in  1  terminate an in-progress dump
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle pulse at end of dump (normal or aborted)
- `debug_enable`  out  1  debug port ownership to data memory
- `debug_addr`  out  D_ADDR_W  debug read address
- `debug_rdata`  in  DATA_W  combinational read data for `debug_addr`
- `out_data`  out  DATA_W  stream data
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready from consumer
- `out_last`  out  1  marks final beat of the dump

## Operation
- States: IDLE, FILL, STREAM, CSUM (macro only), DONE.
- IDLE, `start`=1:
  - latch `fetch_addr`<=`start_addr` and `remaining`<=min(`length`, D_MEMORY_DEPTH).
  - If `length`==0, go to DONE. Otherwise go to FILL.
- FILL (1 cycle):
  - `debug_enable`=1, `debug_addr`=`fetch_addr`.
  - `out_data`<=`debug_rdata`, `fetch_addr`<=`fetch_addr`+1, go to STREAM.
- STREAM:
  - `debug_enable`=1, `out_valid`=1, `debug_addr`=`fetch_addr` (prefetch of the next word).
  - On handshake (`out_valid`&&`out_ready`):
    - If `remaining`==1, go to DONE (or CSUM with the macro defined).
    - Else `remaining`--, `out_data`<=`debug_rdata`, `fetch_addr`++.
  - No handshake: all registers hold and `out_data` stays stable.
- DONE (1 cycle): `done`=1, `debug_enable`=0, `out_valid`=0, then go to IDLE.
- `out_last`=`out_valid` && `remaining`==1 (without the macro).
- Address arithmetic is modulo 2^D_ADDR_W; a sweep from 0xFFF continues at 0x000.
- `abort`:
  - In FILL, STREAM or CSUM, go to DONE next cycle.
  - A beat with `out_ready`=1 in the abort cycle counts as transferred; no further beats are issued.
  - `out_last` is not asserted for an aborted dump unless the abort cycle's beat was already last.
- `start` in any non-IDLE state is ignored. `abort` in IDLE or DONE is ignored.
- `debug_addr` = `fetch_addr` register in all states. It holds its value in IDLE and is never X.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `debug_enable` 0, `debug_addr` 0, `out_data` 0, `out_valid` 0, `out_last` 0.
- `start` sampled at edge N; FILL occupies N..N+1; `out_valid` is first high in cycle N+2.
- With `out_ready` held high, throughput is one word per cycle. A dump of L words ends with `done` one cycle after the last handshake.
- `debug_enable` is high from FILL through the last STREAM/CSUM cycle and is low during DONE.
- Total `busy` cycles with `out_ready`=1: L+2 (L+3 with the checksum beat).
- `rst` mid-dump immediately returns all outputs to their reset values, releases the port and emits no `done`.

## Configuration
- `DATA_MEMORY_DUMP_CHECKSUM_EN` defined:
  - A running sum modulo 2^DATA_W of all transferred data beats is kept; it is cleared on `start`.
  - After the final data handshake, enter CSUM. CSUM presents one extra beat: `out_data`=sum, `out_last`=1. `debug_enable` stays 1 during CSUM.
  - The final data beat does not carry `out_last`.
  - `length`==0 produces a single checksum beat of 0x00.
  - Abort during CSUM drops the beat.
- Not defined: no CSUM state; `out_last` is on the final data beat.

## Test plan
- Preload mem[0x010..0x013]=0x11,0x22,0x33,0x44; `start_addr`=0x010, `length`=4, `out_ready`=1 -> beats 11,22,33,44 on four consecutive cycles, `out_last` on 0x44, `done` one cycle later, `busy` 6 cycles.
- Same dump with `out_ready` toggling 1,0,0,1,… -> `out_data` stable while stalled, identical beat sequence, no duplicates or drops.
- `start_addr`=0xFFE, `length`=3 -> reads 0xFFE, 0xFFF, 0x000 in order.
- `length`=0 -> no `out_valid`, `done` pulse 1 cycle after start. `length`=0x1FFF -> exactly 4096 beats.
- Abort during beat 2 of 4 with `out_ready`=0 -> only beat 1 delivered, `done` next cycle, `debug_enable` low. Assert `rst` mid-dump -> all outputs 0 asynchronously.
- With `DATA_MEMORY_DUMP_CHECKSUM_EN`: dump of 0x11,0x22,0x33,0x44 -> fifth beat 0xAA with `out_last`. Data 0xFF,0x02 -> checksum 0x01.
